// File: rtl/coin_return_dispenser.sv
// Change-return stage: captures the balance on a return request and pays it out, largest coin first.
// Define COIN_STOCK_EN for finite per-denomination stock with refill and empty flags.
module coin_return_dispenser #(
    parameter int NUM_COINS  = 3,
    parameter int TOTAL_BITS = 31,
    parameter int COIN_VAL0  = 100,
    parameter int COIN_VAL1  = 500,
    parameter int COIN_VAL2  = 1000,
    parameter int STOCK_INIT = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_trigger_return,
    input  logic                  i_wait_expired,
    input  logic [TOTAL_BITS-1:0] i_current_total,
    input  logic                  i_coin_ready,
    output logic [NUM_COINS-1:0]  o_return_coin,
    output logic                  o_coin_valid,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_clear_total,
    output logic [TOTAL_BITS-1:0] o_residual
`ifdef COIN_STOCK_EN
    ,
    input  logic                  i_refill,
    output logic [NUM_COINS-1:0]  o_stock_empty
`endif
);

    localparam int IDX_BITS   = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1;
    localparam int STOCK_BITS = (STOCK_INIT > 0) ? $clog2(STOCK_INIT + 1) : 1;

    // The coin selector is written for exactly three ascending denominations.
    if (NUM_COINS != 3 || !(COIN_VAL0 < COIN_VAL1 && COIN_VAL1 < COIN_VAL2) || STOCK_INIT < 0)
    begin : g_bad_params
        $error("coin_return_dispenser: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        IDLE,
        DISPENSE,
        DONE
    } state_t;

    state_t                  state;
    logic [TOTAL_BITS-1:0]   balance;
    logic [TOTAL_BITS-1:0]   residual;
    logic [NUM_COINS-1:0]    coin_avail;
    logic                    sel_found;
    logic [IDX_BITS-1:0]     sel_idx;
    logic [TOTAL_BITS-1:0]   sel_val;
    logic                    take_coin;

    function automatic logic [TOTAL_BITS-1:0] coin_value(input int idx);
        case (idx)
            0:       return TOTAL_BITS'(COIN_VAL0);
            1:       return TOTAL_BITS'(COIN_VAL1);
            default: return TOTAL_BITS'(COIN_VAL2);
        endcase
    endfunction

    // Ascending scan, so the last fitting denomination wins: largest coin first.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_val   = '0;
        for (int d = 0; d < NUM_COINS; d++) begin
            if (coin_avail[d] && coin_value(d) <= balance) begin
                sel_found = 1'b1;
                sel_idx   = IDX_BITS'(d);
                sel_val   = coin_value(d);
            end
        end
    end

    assign take_coin = (state == DISPENSE) && sel_found && i_coin_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            balance  <= '0;
            residual <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if ((i_trigger_return || i_wait_expired) && i_current_total != '0) begin
                        balance <= i_current_total;
                        state   <= DISPENSE;
                    end
                end
                DISPENSE: begin
                    if (!sel_found) begin
                        residual <= balance;
                        state    <= DONE;
                    end else if (i_coin_ready) begin
                        balance <= balance - sel_val;
                    end
                end
                DONE: begin
                    balance <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef COIN_STOCK_EN
    logic [STOCK_BITS-1:0] stock [NUM_COINS];

    // Refill only while idle so a payout never sees its stock change underneath it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int d = 0; d < NUM_COINS; d++) stock[d] <= STOCK_BITS'(STOCK_INIT);
        end else if (state == IDLE && i_refill) begin
            for (int d = 0; d < NUM_COINS; d++) stock[d] <= STOCK_BITS'(STOCK_INIT);
        end else if (take_coin) begin
            for (int d = 0; d < NUM_COINS; d++) begin
                if (IDX_BITS'(d) == sel_idx) stock[d] <= stock[d] - STOCK_BITS'(1);
            end
        end
    end

    always_comb begin
        o_stock_empty = '0;
        for (int d = 0; d < NUM_COINS; d++) o_stock_empty[d] = (stock[d] == '0);
    end

    assign coin_avail = ~o_stock_empty;
`else
    assign coin_avail = '1;
`endif

    assign o_coin_valid  = (state == DISPENSE) && sel_found;
    assign o_return_coin = o_coin_valid ? ({{(NUM_COINS-1){1'b0}}, 1'b1} << sel_idx) : '0;
    assign o_busy        = (state != IDLE);
    assign o_done        = (state == DONE);
    assign o_clear_total = (state == DONE);
    assign o_residual    = residual;

endmodule

// File: tb/tb_coin_return_dispenser.sv
// Self-checking bench for coin_return_dispenser: vector table, hand sequences and random returns
// checked against a greedy change-making model. Build with COIN_STOCK_EN to cover finite stock.
module tb_coin_return_dispenser;

    localparam int NUM_COINS  = 3;
    localparam int TOTAL_BITS = 31;
    localparam int STOCK_INIT = 1;
    localparam int COIN_VAL [NUM_COINS] = '{100, 500, 1000};
`ifdef COIN_STOCK_EN
    localparam int MODEL_STOCK = STOCK_INIT;
`else
    localparam int MODEL_STOCK = 1000000;
`endif

    logic                  clk;
    logic                  reset_n;
    logic                  i_trigger_return;
    logic                  i_wait_expired;
    logic [TOTAL_BITS-1:0] i_current_total;
    logic                  i_coin_ready;
    logic [NUM_COINS-1:0]  o_return_coin;
    logic                  o_coin_valid;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_clear_total;
    logic [TOTAL_BITS-1:0] o_residual;
`ifdef COIN_STOCK_EN
    logic                  i_refill;
    logic [NUM_COINS-1:0]  o_stock_empty;
`endif

    int tests_run;
    int tests_failed;
    int model_stock [NUM_COINS];

    typedef struct {
        string name;
        int    total;
        bit    trig;
        bit    wexp;
        int    mode;
        bit    retrig;
        string coins;
        int    res;
    } vec_t;

    vec_t vecs [$];

    coin_return_dispenser #(
        .NUM_COINS (NUM_COINS),
        .TOTAL_BITS(TOTAL_BITS),
        .COIN_VAL0 (100),
        .COIN_VAL1 (500),
        .COIN_VAL2 (1000),
        .STOCK_INIT(STOCK_INIT)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_trigger_return(i_trigger_return),
        .i_wait_expired  (i_wait_expired),
        .i_current_total (i_current_total),
        .i_coin_ready    (i_coin_ready),
        .o_return_coin   (o_return_coin),
        .o_coin_valid    (o_coin_valid),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_clear_total   (o_clear_total),
        .o_residual      (o_residual)
`ifdef COIN_STOCK_EN
        ,
        .i_refill        (i_refill),
        .o_stock_empty   (o_stock_empty)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string what, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", what, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int total, input bit trig, input bit wexp, input bit ready);
        i_current_total  = TOTAL_BITS'(total);
        i_trigger_return = trig;
        i_wait_expired   = wexp;
        i_coin_ready     = ready;
    endtask

    function automatic void addVec(input string name, input int total, input bit trig, input bit wexp,
                                   input int mode, input bit retrig, input string coins, input int res);
        vec_t v;
        v.name = name; v.total = total; v.trig = trig; v.wexp = wexp;
        v.mode = mode; v.retrig = retrig; v.coins = coins; v.res = res;
        vecs.push_back(v);
    endfunction

    // Greedy payout by division; coins encoded as one-hot digits "4","2","1".
    function automatic void modelReturn(input int total, output string coins, output int res);
        int bal;
        int take;
        bal   = total;
        coins = "";
        for (int d = NUM_COINS - 1; d >= 0; d--) begin
            take = bal / COIN_VAL[d];
            if (take > model_stock[d]) take = model_stock[d];
            for (int j = 0; j < take; j++) coins = {coins, $sformatf("%0d", 1 << d)};
            bal            = bal - take * COIN_VAL[d];
            model_stock[d] = model_stock[d] - take;
        end
        res = bal;
    endfunction

    task automatic doRefill();
`ifdef COIN_STOCK_EN
        i_refill = 1'b1;
        @(negedge clk);
        i_refill = 1'b0;
`endif
        for (int d = 0; d < NUM_COINS; d++) model_stock[d] = MODEL_STOCK;
    endtask

    // mode: 0 ready held high, 1 ready toggling 1/0, 2 random ready.
    task automatic runReturn(input string name, input int total, input bit trig, input bit wexp,
                             input int mode, input bit retrig, input string coins, input int res);
        logic [2:0] got [$];
        logic [2:0] held;
        logic [2:0] want;
        int         k;
        int         valid_cycles;
        bit         prev_wait;
        bit         done_seen;
        bit         rdy;
        got = {};
        held = '0;
        applyStimulus(total, trig, wexp, 1'b0);
        @(negedge clk);
        if (retrig) applyStimulus(4000, 1'b1, 1'b1, 1'b0);
        else        applyStimulus(4000, 1'b0, 1'b0, 1'b0);
        k = 1; valid_cycles = 0; prev_wait = 1'b0; done_seen = 1'b0;
        while (k <= 60) begin
            if (o_done) begin
                done_seen = 1'b1;
                break;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (k % 2) == 1;
                default: rdy = $urandom_range(0, 9) < 7;
            endcase
            if (o_coin_valid) begin
                valid_cycles++;
                checkOutput({name, " onehot"}, 64'($onehot(o_return_coin)), 64'd1);
                if (prev_wait) checkOutput({name, " held coin"}, o_return_coin, held);
                if (rdy) got.push_back(o_return_coin);
                prev_wait = !rdy;
                held      = o_return_coin;
            end else begin
                checkOutput({name, " idle coin"}, o_return_coin, 0);
                prev_wait = 1'b0;
            end
            i_coin_ready = rdy;
            @(negedge clk);
            k++;
        end
        applyStimulus(0, 1'b0, 1'b0, 1'b0);
        checkOutput({name, " done seen"}, done_seen, 1);
        if (done_seen) begin
            checkOutput({name, " clear"}, o_clear_total, 1);
            checkOutput({name, " busy in done"}, o_busy, 1);
            checkOutput({name, " residual"}, o_residual, res);
            checkOutput({name, " done latency"}, k, valid_cycles + 2);
        end
        checkOutput({name, " coin count"}, got.size(), coins.len());
        for (int i = 0; i < coins.len() && i < got.size(); i++) begin
            want = 3'(coins[i] - 8'd48);
            checkOutput($sformatf("%s coin%0d", name, i), got[i], want);
        end
        @(negedge clk);
        checkOutput({name, " done pulse"}, o_done, 0);
        checkOutput({name, " back idle"}, o_busy, 0);
        checkOutput({name, " residual hold"}, o_residual, res);
    endtask

    task automatic runNoStart(input string name, input int total, input bit trig, input bit wexp);
        applyStimulus(total, trig, wexp, 1'b1);
        repeat (3) begin
            @(negedge clk);
            checkOutput({name, " busy"}, o_busy, 0);
            checkOutput({name, " valid"}, o_coin_valid, 0);
            checkOutput({name, " done"}, o_done, 0);
        end
        applyStimulus(0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int    total;
        bit    trig;
        bit    wexp;
        int    res;
        string coins;
        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
`ifdef COIN_STOCK_EN
        i_refill     = 1'b0;
`endif
        applyStimulus(0, 1'b0, 1'b0, 1'b0);
        for (int d = 0; d < NUM_COINS; d++) model_stock[d] = MODEL_STOCK;
        #1;
        checkOutput("reset valid", o_coin_valid, 0);
        checkOutput("reset coin", o_return_coin, 0);
        checkOutput("reset busy", o_busy, 0);
        checkOutput("reset done", o_done, 0);
        checkOutput("reset clear", o_clear_total, 0);
        checkOutput("reset residual", o_residual, 0);
`ifdef COIN_STOCK_EN
        checkOutput("reset stock empty", o_stock_empty, 0);
`endif
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        addVec("t1600", 1600, 1'b1, 1'b0, 0, 1'b0, "421", 0);
`ifdef COIN_STOCK_EN
        addVec("t2700", 2700, 1'b1, 1'b0, 1, 1'b0, "421", 1100);
        addVec("t2000", 2000, 1'b1, 1'b0, 0, 1'b0, "421", 400);
        addVec("t850",  850,  1'b0, 1'b1, 0, 1'b0, "21", 250);
`else
        addVec("t2700", 2700, 1'b1, 1'b0, 1, 1'b0, "44211", 0);
        addVec("t2000", 2000, 1'b1, 1'b0, 0, 1'b0, "44", 0);
        addVec("t850",  850,  1'b0, 1'b1, 0, 1'b0, "2111", 50);
`endif
        addVec("t50",     50,   1'b0, 1'b1, 0, 1'b0, "", 50);
        addVec("t1",      1,    1'b1, 1'b1, 2, 1'b0, "", 1);
        addVec("t1599",   1599, 1'b0, 1'b1, 0, 1'b0, "42", 99);
        addVec("tretrig", 1600, 1'b1, 1'b0, 1, 1'b1, "421", 0);

        foreach (vecs[i]) begin
            doRefill();
            runReturn(vecs[i].name, vecs[i].total, vecs[i].trig, vecs[i].wexp,
                      vecs[i].mode, vecs[i].retrig, vecs[i].coins, vecs[i].res);
        end

        runNoStart("zero total", 0, 1'b1, 1'b1);

        // Asynchronous reset in the middle of a 2700 payout, after two coins.
        doRefill();
        applyStimulus(2700, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        i_trigger_return = 1'b0;
        checkOutput("arst coin1 valid", o_coin_valid, 1);
        @(negedge clk);
        checkOutput("arst coin2 valid", o_coin_valid, 1);
        @(negedge clk);
        checkOutput("arst coin3 valid", o_coin_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("arst valid", o_coin_valid, 0);
        checkOutput("arst coin", o_return_coin, 0);
        checkOutput("arst busy", o_busy, 0);
        checkOutput("arst done", o_done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, 1'b0);
        for (int d = 0; d < NUM_COINS; d++) model_stock[d] = MODEL_STOCK;
        repeat (3) begin
            @(negedge clk);
            checkOutput("arst idle busy", o_busy, 0);
            checkOutput("arst idle done", o_done, 0);
            checkOutput("arst idle valid", o_coin_valid, 0);
        end
        runReturn("after arst", 1600, 1'b1, 1'b0, 0, 1'b0, "421", 0);

`ifdef COIN_STOCK_EN
        doRefill();
        runReturn("stock2000", 2000, 1'b1, 1'b0, 0, 1'b0, "421", 400);
        checkOutput("stock all empty", o_stock_empty, 3'b111);
        runReturn("stock dry", 700, 1'b1, 1'b0, 0, 1'b0, "", 700);
        doRefill();
        checkOutput("stock refilled", o_stock_empty, 3'b000);
`endif

        doRefill();
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 4) == 0) total = $urandom_range(0, 99);
            else                           total = $urandom_range(1, 4000);
            trig = 1'($urandom_range(0, 1));
            wexp = 1'($urandom_range(0, 1));
            if (total == 0 || !(trig || wexp)) begin
                runNoStart($sformatf("rnd%0d nostart", it), total, trig, wexp);
            end else begin
                modelReturn(total, coins, res);
                runReturn($sformatf("rnd%0d", it), total, trig, wexp, 2, 1'b0, coins, res);
            end
            if ($urandom_range(0, 3) == 0) doRefill();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/coin_return_dispenser.md
# coin_return_dispenser

Change-return stage directly downstream of the wait-time/return-trigger logic in the vending machine. When a return is requested (user trigger or wait-time expiry) it captures the machine's current balance and pays it out one coin per handshake, largest denomination first, to the coin hopper. On completion it pulses a clear request back to the balance-tracking logic and reports any amount that could not be paid out.

## Interface
Parameters:
- NUM_COINS, 3, number of denominations (index 0 = smallest)
- TOTAL_BITS, 31, width of balance values
- COIN_VAL0 / COIN_VAL1 / COIN_VAL2, 100 / 500 / 1000, denomination values, strictly ascending
- STOCK_INIT, 4, per-denomination coin stock after reset/refill (used only with COIN_STOCK_EN)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset_n  in  1  one clock; reset is asynchronous and active-low
- i_trigger_return  in  1  user return request, level sampled at clk edge
- i_wait_expired  in  1  high while the upstream wait time equals 0
- i_current_total  in  TOTAL_BITS  balance currently held by the machine
- i_coin_ready  in  1  hopper accepts the presented coin this cycle
- o_return_coin  out  NUM_COINS  one-hot coin presented to hopper; 0 when not valid
- o_coin_valid  out  1  coin presented
- o_busy  out  1  high in DISPENSE and DONE
- o_done  out  1  one-cycle pulse at end of a return
- o_clear_total  out  1  one-cycle pulse, same cycle as o_done; upstream zeroes its balance
- o_residual  out  TOTAL_BITS  undispensable remainder, valid from o_done until the next start
- i_refill  in  1  (COIN_STOCK_EN only) reload all stocks to STOCK_INIT
- o_stock_empty  out  NUM_COINS  (COIN_STOCK_EN only) bit d high when stock[d] == 0

## Operation
- States: IDLE, DISPENSE, DONE. Registers: state, balance (TOTAL_BITS), residual, stock counters (if enabled).
- IDLE: if (i_trigger_return | i_wait_expired) && i_current_total != 0, then balance <= i_current_total and go to DISPENSE. A zero total causes no start.
- DISPENSE: selection is d = the highest index with COIN_VALd <= balance (and stock[d] != 0 if enabled).
  - If such a d exists: o_coin_valid = 1 and o_return_coin = one-hot(d).
  - On i_coin_ready: balance <= balance - COIN_VALd, and stock[d] decrements.
  - If no d fits: o_coin_valid = 0, residual <= balance, go to DONE.
- DONE: o_done = o_clear_total = 1 for one cycle; balance <= 0; return to IDLE.
- Triggers received while in DISPENSE or DONE are ignored. A new return needs a trigger sampled in IDLE.
- Outputs decode registered state only. o_return_coin therefore stays stable while o_coin_valid && !i_coin_ready.
- Subtraction never underflows because selection guarantees COIN_VALd <= balance.

## Timing
- Reset values: state = IDLE; balance = residual = 0; all outputs 0; stocks = STOCK_INIT.
- Reset is asynchronous. Asserting it mid-dispense immediately drops o_coin_valid and o_return_coin, and discards the balance. No o_done is issued.
- Latency, with start sampled at edge T:
  - first o_coin_valid in cycle T+1
  - one coin per cycle while i_coin_ready is held high
  - after N coins: cycle T+N+1 is DISPENSE with no fit, and o_done is in cycle T+N+2
- Start with balance < COIN_VAL0: o_done in cycle T+2, o_residual = total, no coin presented.
- i_coin_ready while o_coin_valid = 0 has no effect.

## Configuration
- COIN_STOCK_EN defined:
  - Finite per-denomination stock.
  - An empty denomination is skipped in favour of the next smaller one.
  - i_refill is honoured in IDLE only and ignored otherwise.
  - o_stock_empty is present.
  - Residual may be nonzero even when balance >= COIN_VAL0.
- COIN_STOCK_EN undefined: unlimited stock; i_refill and o_stock_empty are absent; residual is always < COIN_VAL0.

## Test plan
- Total 1600, trigger pulse, ready held 1 -> coins 100b, 010b, 001b in consecutive cycles; o_done two cycles after the last coin; residual 0.
- Total 2700, ready toggling 1/0 -> sequence 1000, 1000, 500, 100, 100. The coin is held unchanged during ready-low cycles. The balance is only decremented on handshakes.
- Total 50, i_wait_expired = 1 -> no o_coin_valid; o_done/o_clear_total one cycle in T+2; residual 50.
- reset_n dropped asynchronously after the 2nd coin of 2700 -> outputs 0 immediately. After release, the block is in IDLE with balance 0.
- Total 0 with trigger and expiry both high -> stays IDLE; o_busy stays 0. A trigger during DISPENSE does not restart the block.
- COIN_STOCK_EN, STOCK_INIT = 1, total 2000 -> coins 1000, 500, 100; residual 400; o_stock_empty = 111b. After i_refill, o_stock_empty = 000b.
